// File: rtl/pmem_write_buffer.sv
// Eviction write buffer between L2 and DRAM.
// Buffers writebacks, forwards read hits, drains when L2 is idle.
module pmem_write_buffer #(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  mem_address,
  input  logic [127:0] mem_wdata,
  input  logic         mem_read,
  input  logic         mem_write,
  output logic [127:0] mem_rdata,
  output logic         mem_resp,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  output logic         pmem_read,
  output logic         pmem_write,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RESP,
    READ,
    DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [11:0]    tag_q  [DEPTH];
  logic [11:0]    tag_d  [DEPTH];
  logic [127:0]   line_q [DEPTH];
  logic [127:0]   line_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]  head_q, head_d;
  logic [PW-1:0]  tail_q, tail_d;
  logic [PW:0]    count_q, count_d;
  logic [127:0]   rdata_q, rdata_d;
  logic [11:0]    raddr_q, raddr_d;

  logic [11:0]    req_tag;
  logic           hit;
  logic [PW-1:0]  hit_idx;

  assign req_tag = mem_address[15:4];

  // Tag lookup; coalescing keeps tags unique so at most one hits
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && tag_q[i] == req_tag) begin
        hit     = 1'b1;
        hit_idx = PW'(i);
      end
    end
  end

  // Next-state, FIFO update and response data
  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    line_d  = line_q;
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    rdata_d = rdata_q;
    raddr_d = raddr_q;
    unique case (state_q)
      IDLE: begin
        if (mem_write) begin
          if (hit) begin
            line_d[hit_idx] = mem_wdata;
            state_d = RESP;
          end else if (count_q != FULL) begin
            tag_d[tail_q]   = req_tag;
            line_d[tail_q]  = mem_wdata;
            valid_d[tail_q] = 1'b1;
            tail_d  = tail_q + PW'(1);
            count_d = count_q + 1'b1;
            state_d = RESP;
          end else begin
            state_d = DRAIN;
          end
        end else if (mem_read) begin
          if (hit) begin
            rdata_d = line_q[hit_idx];
            state_d = RESP;
          end else begin
            raddr_d = req_tag;
            state_d = READ;
          end
        end else if (count_q != '0) begin
          state_d = DRAIN;
        end
      end
      READ: begin
        if (pmem_resp) begin
          rdata_d = pmem_rdata;
          state_d = RESP;
        end
      end
      DRAIN: begin
        if (pmem_resp) begin
          valid_d[head_q] = 1'b0;
          head_d  = head_q + PW'(1);
          count_d = count_q - 1'b1;
          state_d = IDLE;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      rdata_q <= '0;
      raddr_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      rdata_q <= rdata_d;
      raddr_q <= raddr_d;
    end
  end

  // Entry payload; qualified by valid_q so no reset needed
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    line_q <= line_d;
  end

  // Outputs decode from state so reset drops them at once
  always_comb begin
    mem_resp     = (state_q == RESP);
    pmem_read    = (state_q == READ);
    pmem_write   = (state_q == DRAIN);
    mem_rdata    = rdata_q;
    pmem_address = '0;
    pmem_wdata   = '0;
    if (state_q == READ) begin
      pmem_address = {raddr_q, 4'h0};
    end else if (state_q == DRAIN) begin
      pmem_address = {tag_q[head_q], 4'h0};
      pmem_wdata   = line_q[head_q];
    end
  end

endmodule

// File: tb/tb_pmem_write_buffer.sv
// Directed bench for pmem_write_buffer.
// Linear steps with immediate assertions at each check.
module tb_pmem_write_buffer;

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  mem_address;
  logic [127:0] mem_wdata;
  logic         mem_read;
  logic         mem_write;
  logic [127:0] mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] LA = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
  localparam logic [127:0] LB = 128'hBBBB_1111_BBBB_2222_BBBB_3333_BBBB_4444;
  localparam logic [127:0] LC = 128'hCCCC_5555_CCCC_6666_CCCC_7777_CCCC_8888;
  localparam logic [127:0] LD = 128'hDDDD_0000_1234_5678_9ABC_DEF0_DDDD_0000;
  localparam logic [127:0] LE = 128'hEEEE_EEEE_0BAD_F00D_EEEE_EEEE_CAFE_BEEF;
  localparam logic [127:0] LF = 128'hF0F0_F0F0_0F0F_0F0F_F0F0_F0F0_0F0F_0F0F;

  pmem_write_buffer #(.DEPTH(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string t,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", t, obs, exp);
    end
  endtask

  // Write with the exact one-cycle accept latency checked
  task automatic wr(input string t,
                    input logic [15:0] a,
                    input logic [127:0] d);
    mem_write   = 1'b1;
    mem_address = a;
    mem_wdata   = d;
    tick();
    chk({t, "_resp"}, mem_resp, 1);
    mem_write = 1'b0;
  endtask

  // Wait (bounded) for a drain, check it, then complete it
  task automatic drain_one(input string t,
                           input logic [15:0] a,
                           input logic [127:0] d);
    int n = 0;
    while (pmem_write !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({t, "_go"},  pmem_write, 1);
    chk({t, "_adr"}, pmem_address, a);
    chk({t, "_dat"}, pmem_wdata, d);
    chk({t, "_nrd"}, pmem_read, 0);
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    mem_address = 16'($urandom);
    mem_wdata   = {4{32'($urandom)}};
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    pmem_rdata  = {4{32'($urandom)}};
    pmem_resp   = 1'b0;

    // 1: reset state
    tick();
    tick();
    chk("rst_resp", mem_resp, 0);
    chk("rst_pwr",  pmem_write, 0);
    chk("rst_prd",  pmem_read, 0);
    reset = 1'b0;
    tick();
    chk("post_rdata", mem_rdata, 0);
    chk("post_wdata", pmem_wdata, 0);
    chk("post_addr",  pmem_address, 0);
    chk("post_cnt",   dut.count_q, 0);
    tick();
    tick();
    chk("idle_pwr", pmem_write, 0);
    chk("idle_prd", pmem_read, 0);

    // 2: write accepted at N+1, then drained
    wr("t2", 16'h1230, LA);
    tick();
    chk("t2_idle_resp", mem_resp, 0);
    drain_one("t2_dr", 16'h1230, LA);
    chk("t2_cnt", dut.count_q, 0);

    // 3: read hit forwards the buffered line
    wr("t3", 16'h1230, LA);
    mem_read    = 1'b1;
    mem_address = 16'h1238;
    tick();
    chk("t3_gap", mem_resp, 0);
    tick();
    chk("t3_hit_resp",  mem_resp, 1);
    chk("t3_hit_data",  mem_rdata, LA);
    chk("t3_no_prd",    pmem_read, 0);
    mem_read = 1'b0;
    drain_one("t3_dr", 16'h1230, LA);

    // 4: third write stalls on full, drain order preserved
    wr("t4a", 16'h1000, LA);
    tick();
    wr("t4b", 16'h2000, LB);
    tick();
    mem_write   = 1'b1;
    mem_address = 16'h3000;
    mem_wdata   = LC;
    tick();
    chk("t4_stall",  mem_resp, 0);
    chk("t4_dr1_go", pmem_write, 1);
    chk("t4_dr1_a",  pmem_address, 16'h1000);
    chk("t4_dr1_d",  pmem_wdata, LA);
    tick();
    tick();
    chk("t4_stall2", mem_resp, 0);
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    chk("t4_stall3", mem_resp, 0);
    tick();
    chk("t4c_resp", mem_resp, 1);
    mem_write = 1'b0;
    drain_one("t4_dr2", 16'h2000, LB);
    drain_one("t4_dr3", 16'h3000, LC);
    chk("t4_cnt", dut.count_q, 0);

    // 5: coalesced writes give one DRAM write with newest data
    wr("t5a", 16'h1000, LA);
    tick();
    wr("t5b", 16'h1000, LB);
    drain_one("t5_dr", 16'h1000, LB);
    tick();
    tick();
    tick();
    chk("t5_once", pmem_write, 0);
    chk("t5_cnt",  dut.count_q, 0);

    // 6: read miss waits for an active drain
    wr("t6", 16'h5000, LD);
    tick();
    tick();
    chk("t6_drain", pmem_write, 1);
    mem_read    = 1'b1;
    mem_address = 16'h4000;
    tick();
    chk("t6_rd_wait", pmem_read, 0);
    chk("t6_dr_hold", pmem_address, 16'h5000);
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    chk("t6_idle_prd", pmem_read, 0);
    chk("t6_idle_pwr", pmem_write, 0);
    tick();
    chk("t6_prd",   pmem_read, 1);
    chk("t6_padr",  pmem_address, 16'h4000);
    chk("t6_excl",  pmem_write, 0);
    pmem_rdata = LE;
    pmem_resp  = 1'b1;
    tick();
    pmem_resp = 1'b0;
    chk("t6_resp",  mem_resp, 1);
    chk("t6_rdata", mem_rdata, LE);
    mem_read = 1'b0;
    tick();
    chk("t6_resp_off", mem_resp, 0);

    // 6b: reset mid-READ drops pmem_read and loses buffered data
    wr("t6b", 16'h7000, LF);
    mem_read    = 1'b1;
    mem_address = 16'h6000;
    tick();
    tick();
    chk("t6b_prd",  pmem_read, 1);
    chk("t6b_padr", pmem_address, 16'h6000);
    reset = 1'b1;
    #1;
    chk("t6b_async_prd", pmem_read, 0);
    chk("t6b_async_adr", pmem_address, 0);
    chk("t6b_async_rd",  mem_rdata, 0);
    mem_read = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("t6b_cnt", dut.count_q, 0);
    tick();
    tick();
    tick();
    chk("t6b_lost_pwr", pmem_write, 0);
    chk("t6b_lost_prd", pmem_read, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
